exc_ctrl: RTL and testbench

- Exception entry/return sequencer. Generates the mode-change, SPSR-save and CPSR-write command stream consumed by the CPSR/SPSR register file, and loads the exception vector into the PC.
- Samples IRQ/FIQ lines and SWI/UND flags from decode at instruction boundaries, honours the CPSR I/F masks, and sequences the save/mode/vector steps.
- Handles exception return (S-suffixed write to PC) by restoring CPSR from the current mode's SPSR.
- Sits between decode/fetch and the PSR register file; stalls the pipeline while active.

---
 rtl/exc_pkg.sv | 79 +++++++
 rtl/exc_ctrl_if.sv | 36 +++
 rtl/exc_prio.sv | 32 +++
 rtl/exc_ctrl.sv | 110 +++++++++++
 tb/tb_exc_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// Shared encodings for the exception sequencer: FSM states, PSR file command codes,
// vector offsets and the per-exception lookup helpers.
package exc_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SAVE = 3'd1,
        S_MODE = 3'd2,
        S_VECT = 3'd3,
        S_RET  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EXC_FIQ = 2'd0,
        EXC_IRQ = 2'd1,
        EXC_UND = 2'd2,
        EXC_SWI = 2'd3
    } exc_t;

    // Change_M codes
    localparam logic [2:0] CM_CUR = 3'd0;
    localparam logic [2:0] CM_FIQ = 3'd1;
    localparam logic [2:0] CM_IRQ = 3'd2;
    localparam logic [2:0] CM_SVC = 3'd3;
    localparam logic [2:0] CM_UND = 3'd4;

    // W_CPSR_s codes
    localparam logic [2:0] WC_SPSR = 3'd0;
    localparam logic [2:0] WC_IRQ  = 3'd2;
    localparam logic [2:0] WC_FIQ  = 3'd3;
    localparam logic [2:0] WC_SVC  = 3'd4;
    localparam logic [2:0] WC_UND  = 3'd5;

    localparam logic [31:0] VO_FIQ = 32'h0000_001C;
    localparam logic [31:0] VO_IRQ = 32'h0000_0018;
    localparam logic [31:0] VO_SWI = 32'h0000_0008;
    localparam logic [31:0] VO_UND = 32'h0000_0004;

    // One cycle's worth of commands to the PSR file and PC
    typedef struct packed {
        logic [2:0]  change_m;
        logic        w_spsr_s;
        logic        write_spsr;
        logic [2:0]  w_cpsr_s;
        logic        write_cpsr;
        logic        lr_we;
        logic [31:0] lr_data;
        logic        pc_load;
        logic [31:0] pc_vec;
    } psr_cmd_t;

    function automatic logic [2:0] mode_of(exc_t t);
        case (t)
            EXC_FIQ: return CM_FIQ;
            EXC_IRQ: return CM_IRQ;
            EXC_UND: return CM_UND;
            default: return CM_SVC;
        endcase
    endfunction

    function automatic logic [2:0] cpsr_src_of(exc_t t);
        case (t)
            EXC_FIQ: return WC_FIQ;
            EXC_IRQ: return WC_IRQ;
            EXC_UND: return WC_UND;
            default: return WC_SVC;
        endcase
    endfunction

    function automatic logic [31:0] vec_ofs_of(exc_t t);
        case (t)
            EXC_FIQ: return VO_FIQ;
            EXC_IRQ: return VO_IRQ;
            EXC_UND: return VO_UND;
            default: return VO_SWI;
        endcase
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Decode/fetch-side requests and PSR-file/PC command outputs of the exception sequencer.
interface exc_ctrl_if;
    logic        irq;
    logic        fiq;
    logic        swi_req;
    logic        und_req;
    logic        eret_req;
    logic        inst_done;
    logic [31:0] pc_ret;
    logic [31:0] lr_cur;
    logic [31:0] CPSR;

    logic [2:0]  Change_M;
    logic        W_SPSR_s;
    logic        Write_SPSR;
    logic [2:0]  W_CPSR_s;
    logic        Write_CPSR;
    logic        lr_we;
    logic [31:0] lr_data;
    logic        pc_load;
    logic [31:0] pc_vec;
    logic        stall;
    logic        busy;

    modport master (
        output irq, fiq, swi_req, und_req, eret_req, inst_done, pc_ret, lr_cur, CPSR,
        input  Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR,
               lr_we, lr_data, pc_load, pc_vec, stall, busy
    );

    modport slave (
        input  irq, fiq, swi_req, und_req, eret_req, inst_done, pc_ret, lr_cur, CPSR,
        output Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR,
               lr_we, lr_data, pc_load, pc_vec, stall, busy
    );
endinterface

// File: rtl/exc_prio.sv
// Masking and priority selection of boundary requests: eret > fiq > irq > und > swi.
module exc_prio
    import exc_pkg::*;
(
    input  logic       irq,
    input  logic       fiq,
    input  logic       und_req,
    input  logic       swi_req,
    input  logic       eret_req,
    input  logic [1:0] if_mask,   // {CPSR.I, CPSR.F}
    output logic       take,
    output exc_t       exc_type,
    output logic       is_eret
);

    always_comb begin
        take     = 1'b1;
        is_eret  = 1'b0;
        exc_type = EXC_SWI;
        if (eret_req)
            is_eret = 1'b1;
        else if (fiq && !if_mask[0])
            exc_type = EXC_FIQ;
        else if (irq && !if_mask[1])
            exc_type = EXC_IRQ;
        else if (und_req)
            exc_type = EXC_UND;
        else if (!swi_req)
            take = 1'b0;
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception entry/return sequencer: SAVE -> MODE -> VECT on entry, single-cycle RET on return.
// Outputs are registered from the next state so each command lines up with its state.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
    parameter logic [31:0] IRQ_LR_OFS = 32'd4
) (
    input logic          clk,
    input logic          rst,
    exc_ctrl_if.slave    bus
);

    state_t   state, state_n;
    exc_t     type_q, cur_type, prio_type;
    logic     prio_take, prio_eret;
    psr_cmd_t cmd_d, cmd_q;

    // Only I/F participate in entry decisions
    logic cpsr_unused;
    assign cpsr_unused = ^{bus.CPSR[31:8], bus.CPSR[5:0]};

    exc_prio u_prio (
        .irq      (bus.irq),
        .fiq      (bus.fiq),
        .und_req  (bus.und_req),
        .swi_req  (bus.swi_req),
        .eret_req (bus.eret_req),
        .if_mask  (bus.CPSR[7:6]),
        .take     (prio_take),
        .exc_type (prio_type),
        .is_eret  (prio_eret)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            type_q <= EXC_FIQ;
        end else begin
            state <= state_n;
            if (state == S_IDLE)
                type_q <= prio_type;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.inst_done && prio_take)
                         state_n = prio_eret ? S_RET : S_SAVE;
            S_SAVE:  state_n = S_MODE;
            S_MODE:  state_n = S_VECT;
            S_VECT:  state_n = S_IDLE;
            S_RET:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Entering SAVE uses the type being accepted this cycle; later steps use the latched one
    assign cur_type = (state == S_IDLE) ? prio_type : type_q;

    always_comb begin
        cmd_d = '0;
        case (state_n)
            S_SAVE: begin
                cmd_d.change_m   = mode_of(cur_type);
                cmd_d.w_spsr_s   = 1'b1;
                cmd_d.write_spsr = 1'b1;
                cmd_d.lr_we      = 1'b1;
                cmd_d.lr_data    = bus.pc_ret +
                    ((cur_type == EXC_IRQ || cur_type == EXC_FIQ) ? IRQ_LR_OFS : 32'd0);
            end
            S_MODE: begin
                cmd_d.change_m   = mode_of(cur_type);
                cmd_d.w_cpsr_s   = cpsr_src_of(cur_type);
                cmd_d.write_cpsr = 1'b1;
            end
            S_VECT: begin
                cmd_d.pc_load = 1'b1;
                cmd_d.pc_vec  = VEC_BASE + vec_ofs_of(cur_type);
            end
            S_RET: begin
                cmd_d.change_m   = CM_CUR;
                cmd_d.w_cpsr_s   = WC_SPSR;
                cmd_d.write_cpsr = 1'b1;
                cmd_d.pc_load    = 1'b1;
                cmd_d.pc_vec     = bus.lr_cur;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cmd_q <= '0;
        else      cmd_q <= cmd_d;
    end

    assign bus.Change_M   = cmd_q.change_m;
    assign bus.W_SPSR_s   = cmd_q.w_spsr_s;
    assign bus.Write_SPSR = cmd_q.write_spsr;
    assign bus.W_CPSR_s   = cmd_q.w_cpsr_s;
    assign bus.Write_CPSR = cmd_q.write_cpsr;
    assign bus.lr_we      = cmd_q.lr_we;
    assign bus.lr_data    = cmd_q.lr_data;
    assign bus.pc_load    = cmd_q.pc_load;
    assign bus.pc_vec     = cmd_q.pc_vec;
    assign bus.busy       = (state != S_IDLE);
    assign bus.stall      = (state != S_IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: vector table of boundary requests with expected command streams
// queued per cycle, plus hand sequences for reset, busy-ignore and reset abort.
module tb_exc_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exc_ctrl_if bus();

    exc_ctrl #(.VEC_BASE(32'h0000_0000), .IRQ_LR_OFS(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]  change_m;
        logic        w_spsr_s;
        logic        write_spsr;
        logic [2:0]  w_cpsr_s;
        logic        write_cpsr;
        logic        lr_we;
        logic [31:0] lr_data;
        logic        pc_load;
        logic [31:0] pc_vec;
        logic        stall;
        logic        busy;
    } out_t;

    typedef struct {
        out_t  v;
        out_t  m;
        string tag;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] cpsr, pc_ret, lr_cur;
        logic        irq, fiq, swi, und, eret, hold;
        int          kind;    // 0 none, 1 entry, 2 return
        logic [2:0]  cm, wc;
        logic [31:0] lr, vec;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic out_t strobe_mask();
        out_t m = '0;
        m.write_spsr = 1'b1; m.write_cpsr = 1'b1; m.lr_we = 1'b1;
        m.pc_load = 1'b1; m.stall = 1'b1; m.busy = 1'b1;
        return m;
    endfunction

    function automatic exp_t e_idle();
        exp_t e;
        e.v = '0; e.m = strobe_mask(); e.tag = "idle";
        return e;
    endfunction

    function automatic exp_t e_zero();
        exp_t e;
        e.v = '0; e.m = '1; e.tag = "zero";
        return e;
    endfunction

    function automatic exp_t e_save(logic [2:0] cm, logic [31:0] lr);
        exp_t e = e_idle();
        e.v.change_m = cm; e.v.w_spsr_s = 1'b1; e.v.write_spsr = 1'b1;
        e.v.lr_we = 1'b1; e.v.lr_data = lr; e.v.stall = 1'b1; e.v.busy = 1'b1;
        e.m.change_m = '1; e.m.w_spsr_s = 1'b1; e.m.lr_data = '1;
        e.tag = "save";
        return e;
    endfunction

    function automatic exp_t e_mode(logic [2:0] cm, logic [2:0] wc);
        exp_t e = e_idle();
        e.v.change_m = cm; e.v.w_cpsr_s = wc; e.v.write_cpsr = 1'b1;
        e.v.stall = 1'b1; e.v.busy = 1'b1;
        e.m.change_m = '1; e.m.w_cpsr_s = '1;
        e.tag = "mode";
        return e;
    endfunction

    function automatic exp_t e_vect(logic [31:0] vec);
        exp_t e = e_idle();
        e.v.pc_load = 1'b1; e.v.pc_vec = vec; e.v.stall = 1'b1; e.v.busy = 1'b1;
        e.m.pc_vec = '1;
        e.tag = "vect";
        return e;
    endfunction

    function automatic exp_t e_ret(logic [31:0] vec);
        exp_t e = e_idle();
        e.v.write_cpsr = 1'b1; e.v.pc_load = 1'b1; e.v.pc_vec = vec;
        e.v.stall = 1'b1; e.v.busy = 1'b1;
        e.m.change_m = '1; e.m.w_cpsr_s = '1; e.m.pc_vec = '1;
        e.tag = "ret";
        return e;
    endfunction

    function automatic vec_t mkv(string name, logic [31:0] cpsr, logic [31:0] pc_ret,
                                 logic [31:0] lr_cur, logic [4:0] req, logic hold,
                                 int kind, logic [2:0] cm, logic [2:0] wc,
                                 logic [31:0] lr, logic [31:0] vec);
        vec_t v;
        v.name = name; v.cpsr = cpsr; v.pc_ret = pc_ret; v.lr_cur = lr_cur;
        {v.irq, v.fiq, v.swi, v.und, v.eret} = req;
        v.hold = hold; v.kind = kind; v.cm = cm; v.wc = wc; v.lr = lr; v.vec = vec;
        return v;
    endfunction

    function automatic out_t actual();
        out_t a;
        a.change_m = bus.Change_M;   a.w_spsr_s = bus.W_SPSR_s;
        a.write_spsr = bus.Write_SPSR; a.w_cpsr_s = bus.W_CPSR_s;
        a.write_cpsr = bus.Write_CPSR; a.lr_we = bus.lr_we;
        a.lr_data = bus.lr_data;     a.pc_load = bus.pc_load;
        a.pc_vec = bus.pc_vec;       a.stall = bus.stall; a.busy = bus.busy;
        return a;
    endfunction

    task automatic check(input string name, input exp_t e);
        out_t a;
        a = actual();
        checks++;
        if (((a ^ e.v) & e.m) != '0) begin
            errors++;
            $display("FAIL %s/%s: got %h want %h (care %h)", name, e.tag, a, e.v, e.m);
        end
    endtask

    task automatic drain(input string name);
        while (sbq.size() > 0) begin
            @(negedge clk);
            check(name, sbq.pop_front());
        end
    endtask

    task automatic clear_req();
        bus.inst_done = 1'b0; bus.swi_req = 1'b0; bus.und_req = 1'b0; bus.eret_req = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk); #1;
        bus.CPSR = v.cpsr; bus.pc_ret = v.pc_ret; bus.lr_cur = v.lr_cur;
        bus.irq = v.irq; bus.fiq = v.fiq; bus.swi_req = v.swi; bus.und_req = v.und;
        bus.eret_req = v.eret; bus.inst_done = 1'b1;
        case (v.kind)
            1: begin
                sbq.push_back(e_save(v.cm, v.lr));
                sbq.push_back(e_mode(v.cm, v.wc));
                sbq.push_back(e_vect(v.vec));
                sbq.push_back(e_idle());
            end
            2: begin
                sbq.push_back(e_ret(v.vec));
                sbq.push_back(e_idle());
            end
            default: begin
                sbq.push_back(e_idle());
                sbq.push_back(e_idle());
            end
        endcase
        @(posedge clk); #1;
        clear_req();
        if (!v.hold) begin bus.irq = 1'b0; bus.fiq = 1'b0; end
        drain(v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // req = {irq, fiq, swi, und, eret}
        tbl.push_back(mkv("irq_first", 32'h10, 32'h000, 32'h0, 5'b10000, 0, 1, 3'd2, 3'd2, 32'h004, 32'h18));
        tbl.push_back(mkv("irq_entry", 32'h10, 32'h100, 32'h0, 5'b10000, 0, 1, 3'd2, 3'd2, 32'h104, 32'h18));
        tbl.push_back(mkv("irq_mask",  32'h90, 32'h100, 32'h0, 5'b10000, 0, 0, 3'd0, 3'd0, 32'h0,   32'h0));
        tbl.push_back(mkv("both_mask", 32'hD0, 32'h100, 32'h0, 5'b11000, 0, 0, 3'd0, 3'd0, 32'h0,   32'h0));
        tbl.push_back(mkv("fiq_win",   32'h80, 32'h040, 32'h0, 5'b11000, 0, 1, 3'd1, 3'd3, 32'h044, 32'h1C));
        tbl.push_back(mkv("fiq_prio",  32'h10, 32'h070, 32'h0, 5'b11000, 0, 1, 3'd1, 3'd3, 32'h074, 32'h1C));
        tbl.push_back(mkv("swi",       32'h10, 32'h204, 32'h0, 5'b00100, 0, 1, 3'd3, 3'd4, 32'h204, 32'h08));
        tbl.push_back(mkv("und",       32'h10, 32'h050, 32'h0, 5'b00010, 0, 1, 3'd4, 3'd5, 32'h050, 32'h04));
        tbl.push_back(mkv("swi_irq",   32'h10, 32'h060, 32'h0, 5'b10100, 0, 1, 3'd2, 3'd2, 32'h064, 32'h18));
        tbl.push_back(mkv("und_masked",32'hC0, 32'h088, 32'h0, 5'b11010, 0, 1, 3'd4, 3'd5, 32'h088, 32'h04));
        tbl.push_back(mkv("und_swi",   32'h10, 32'h0A0, 32'h0, 5'b00110, 0, 1, 3'd4, 3'd5, 32'h0A0, 32'h04));
        tbl.push_back(mkv("eret_irq",  32'h92, 32'h0,  32'h300, 5'b10001, 1, 2, 3'd0, 3'd0, 32'h0, 32'h300));
        tbl.push_back(mkv("irq_after", 32'h10, 32'h300, 32'h0, 5'b10000, 0, 1, 3'd2, 3'd2, 32'h304, 32'h18));
        tbl.push_back(mkv("eret_fiq",  32'h11, 32'h0, 32'h1234, 5'b01001, 0, 2, 3'd0, 3'd0, 32'h0, 32'h1234));
        tbl.push_back(mkv("nothing",   32'h10, 32'h0,  32'h0,  5'b00000, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0));

        // Reset with a live request and a boundary strobe: everything stays zero
        rst = 1'b0;
        bus.CPSR = 32'h10; bus.pc_ret = '0; bus.lr_cur = '0;
        bus.irq = 1'b1; bus.fiq = 1'b0; clear_req(); bus.inst_done = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", e_zero());
        @(posedge clk); #1;
        rst = 1'b1; bus.inst_done = 1'b0;

        // irq held without a boundary strobe is never sampled
        repeat (3) sbq.push_back(e_idle());
        drain("no_boundary");
        bus.irq = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Requests arriving while busy are ignored
        @(posedge clk); #1;
        bus.CPSR = 32'h10; bus.pc_ret = 32'h400; bus.irq = 1'b1; bus.inst_done = 1'b1;
        sbq.push_back(e_save(3'd2, 32'h404));
        sbq.push_back(e_mode(3'd2, 3'd2));
        sbq.push_back(e_vect(32'h18));
        sbq.push_back(e_idle());
        sbq.push_back(e_idle());
        @(posedge clk); #1;
        bus.irq = 1'b0; bus.swi_req = 1'b1; bus.eret_req = 1'b1;
        @(negedge clk); check("busy_ign", sbq.pop_front());
        @(posedge clk); #1;
        @(negedge clk); check("busy_ign", sbq.pop_front());
        @(posedge clk); #1;
        clear_req();
        drain("busy_ign");

        // Reset asserted during MODE aborts the sequence at once
        @(posedge clk); #1;
        bus.CPSR = 32'h10; bus.pc_ret = 32'h500; bus.irq = 1'b1; bus.inst_done = 1'b1;
        sbq.push_back(e_save(3'd2, 32'h504));
        sbq.push_back(e_mode(3'd2, 3'd2));
        @(posedge clk); #1;
        clear_req(); bus.irq = 1'b0;
        drain("mid_rst");
        #2 rst = 1'b0;
        #1 check("mid_rst_abort", e_zero());
        @(posedge clk); #1;
        rst = 1'b1;
        sbq.push_back(e_idle());
        sbq.push_back(e_idle());
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
